// File: rtl/button_event_ctrl.sv
// Per-button press/long/repeat event generator with a shared
// round-robin event output, one pending slot per button.
module button_event_ctrl #(
  parameter int   N_BTN      = 4,
  parameter int   CLK_HZ     = 27000000,
  parameter int   LONG_MS    = 1000,
  parameter int   REPEAT_MS  = 200,
  parameter logic IDLE_STATE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [2:0]       ev_btn,
  output logic [1:0]       ev_type,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [15:0] LONG_C = 16'(LONG_MS);
  localparam logic [15:0] REP_C  = 16'(REPEAT_MS);

  localparam logic [1:0] E_PRESS  = 2'b00;
  localparam logic [1:0] E_SHORT  = 2'b01;
  localparam logic [1:0] E_LONG   = 2'b10;
  localparam logic [1:0] E_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } st_t;

  logic [PW-1:0]    pre;
  logic             tick;
  logic [N_BTN-1:0] act;

  st_t         st    [N_BTN];
  st_t         st_nx [N_BTN];
  logic [15:0] ms    [N_BTN];
  logic [15:0] ms_nx [N_BTN];

  logic [N_BTN-1:0] nev;
  logic [1:0]       ntype [N_BTN];
  logic [N_BTN-1:0] pend;
  logic [1:0]       ptype [N_BTN];

  logic             load;
  logic             take;
  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic [1:0]       sel_type;
  logic [N_BTN-1:0] gnt;
  logic [2:0]       rr_ptr;
  logic [2:0]       rr_nx;
  logic             drop;

  assign tick = (pre == PW'(DIV - 1));
  assign act  = btn_in ^ {N_BTN{IDLE_STATE}};

  always_ff @(posedge clk) begin
    if (!rstn)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (!rstn) begin
        st[i] <= S_IDLE;
        ms[i] <= '0;
      end else begin
        st[i] <= st_nx[i];
        ms[i] <= ms_nx[i];
      end
    end
  end

  // Release is checked before the tick, so it wins over a threshold.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_nx[i] = st[i];
      ms_nx[i] = ms[i];
      case (st[i])
        S_IDLE: if (act[i]) begin
          st_nx[i] = S_PRESSED;
          ms_nx[i] = '0;
        end
        S_PRESSED: begin
          if (!act[i]) begin
            st_nx[i] = S_IDLE;
          end else if (tick) begin
            if (ms[i] + 16'd1 == LONG_C) begin
              st_nx[i] = S_HELD;
              ms_nx[i] = '0;
            end else begin
              ms_nx[i] = ms[i] + 16'd1;
            end
          end
        end
        S_HELD: begin
          if (!act[i]) begin
            st_nx[i] = S_IDLE;
          end else if (tick) begin
            if (ms[i] + 16'd1 == REP_C) ms_nx[i] = '0;
            else                        ms_nx[i] = ms[i] + 16'd1;
          end
        end
        default: st_nx[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      nev[i]   = 1'b0;
      ntype[i] = E_PRESS;
      case (st[i])
        S_IDLE: if (act[i]) nev[i] = 1'b1;
        S_PRESSED: begin
          if (!act[i]) begin
            nev[i]   = 1'b1;
            ntype[i] = E_SHORT;
          end else if (tick && (ms[i] + 16'd1 == LONG_C)) begin
            nev[i]   = 1'b1;
            ntype[i] = E_LONG;
          end
        end
        S_HELD: if (act[i] && tick && (ms[i] + 16'd1 == REP_C)) begin
          nev[i]   = 1'b1;
          ntype[i] = E_REPEAT;
        end
        default: nev[i] = 1'b0;
      endcase
    end
  end

  assign load = !ev_valid || ev_ready;
  assign take = load && gnt_any;

  always_comb begin
    int j;
    j        = 0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    sel_type = '0;
    rr_nx    = rr_ptr;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!gnt_any && pend[j]) begin
        gnt_any  = 1'b1;
        gnt_idx  = 3'(j);
        sel_type = ptype[j];
        rr_nx    = (j + 1 >= N_BTN) ? 3'd0 : 3'(j + 1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      gnt[i] = take && (gnt_idx == 3'(i));
    end
  end

  assign drop = |(nev & pend & ~gnt);

  // A slot being granted this cycle is free for the new event.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (!rstn) begin
        pend[i]  <= 1'b0;
        ptype[i] <= '0;
      end else if (nev[i] && (!pend[i] || gnt[i])) begin
        pend[i]  <= 1'b1;
        ptype[i] <= ntype[i];
      end else if (gnt[i]) begin
        pend[i]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ev_valid <= 1'b0;
      ev_btn   <= '0;
      ev_type  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      ev_valid <= gnt_any;
      if (gnt_any) begin
        ev_btn  <= gnt_idx;
        ev_type <= sel_type;
        rr_ptr  <= rr_nx;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: hold-time based event model plus
// directed scenarios with literal expectations.
module tb_button_event_ctrl;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] btn_in = 4'hF;
  logic       ev_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_btn;
  logic [1:0] ev_type;
  logic       ovf;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN(N), .CLK_HZ(4000), .LONG_MS(LONG),
    .REPEAT_MS(REP), .IDLE_STATE(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .btn_in(btn_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_btn(ev_btn), .ev_type(ev_type),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  // Model: each button tracks whether it is down and how many
  // ms ticks it has been held; events follow from that count.
  bit m_pr [N];
  int m_t  [N];
  int m_n;
  bit m_pend [N];
  int m_pty  [N];
  bit m_v;
  int m_b, m_ty, m_rr;
  bit m_ovf;
  bit m_tk, m_found, m_drop, m_act;
  bit m_nev [N];
  int m_nty [N];
  bit m_gr  [N];
  int m_g, m_j;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (!rstn) begin
      m_n = 0; m_v = 0; m_b = 0; m_ty = 0; m_rr = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        m_pr[i] = 0; m_t[i] = 0; m_pend[i] = 0; m_pty[i] = 0;
      end
    end else begin
      m_tk = (m_n % DIV) == DIV - 1;
      m_n++;
      for (int i = 0; i < N; i++) begin
        m_act = (btn_in[i] == 1'b0);
        m_nev[i] = 0;
        m_nty[i] = 0;
        m_gr[i] = 0;
        if (m_act && !m_pr[i]) begin
          m_nev[i] = 1; m_nty[i] = 0; m_pr[i] = 1; m_t[i] = 0;
        end else if (!m_act && m_pr[i]) begin
          m_pr[i] = 0;
          if (m_t[i] < LONG) begin m_nev[i] = 1; m_nty[i] = 1; end
        end else if (m_act && m_tk) begin
          m_t[i]++;
          if (m_t[i] == LONG) begin
            m_nev[i] = 1; m_nty[i] = 2;
          end else if (m_t[i] > LONG && (m_t[i] - LONG) % REP == 0) begin
            m_nev[i] = 1; m_nty[i] = 3;
          end
        end
      end
      m_found = 0; m_g = 0;
      for (int k = 0; k < N; k++) begin
        m_j = (m_rr + k) % N;
        if (!m_found && m_pend[m_j]) begin m_found = 1; m_g = m_j; end
      end
      if (!m_v || ev_ready) begin
        m_v = m_found;
        if (m_found) begin
          m_b = m_g; m_ty = m_pty[m_g]; m_rr = (m_g + 1) % N;
          m_gr[m_g] = 1;
        end
      end
      m_drop = 0;
      for (int i = 0; i < N; i++) begin
        if (m_nev[i]) begin
          if (m_pend[i] && !m_gr[i]) m_drop = 1;
          else begin m_pend[i] = 1; m_pty[i] = m_nty[i]; end
        end else if (m_gr[i]) begin
          m_pend[i] = 0;
        end
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  typedef struct { int b; int t; int c; } ev_t;
  ev_t lg[$];

  always @(negedge clk) begin
    if (started) begin
      chk("valid", ev_valid, m_v);
      if (m_v) begin
        chk("btn", ev_btn, m_b);
        chk("type", ev_type, m_ty);
      end
      chk("ovf", ovf, m_ovf);
      if (ev_valid === 1'b1 && ev_ready) begin
        lg.push_back('{int'(ev_btn), int'(ev_type), cyc});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ev(input string nm, input int idx,
                        input int b, input int t);
    chk({nm, "_present"}, lg.size() > idx, 1);
    if (lg.size() > idx) begin
      chk({nm, "_btn"}, lg[idx].b, b);
      chk({nm, "_type"}, lg[idx].t, t);
    end
  endtask

  int c0;

  initial begin
    step(3);
    chk("rst_valid", ev_valid, 0);
    chk("rst_btn", ev_btn, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;
    step(2);

    // short press of button 2
    lg.delete();
    c0 = cyc;
    btn_in = 4'b1011;
    step(20);
    btn_in = 4'hF;
    step(10);
    chk("short_count", lg.size(), 2);
    chk_ev("short_press", 0, 2, 0);
    chk_ev("short_rel", 1, 2, 1);
    if (lg.size() > 0) chk("latency", lg[0].c - c0, 2);

    // long hold of button 0
    lg.delete();
    btn_in = 4'b1110;
    step(82);
    btn_in = 4'hF;
    step(20);
    chk("long_count", lg.size(), 5);
    chk_ev("long_press", 0, 0, 0);
    chk_ev("long_long", 1, 0, 2);
    chk_ev("long_rep1", 2, 0, 3);
    chk_ev("long_rep2", 3, 0, 3);
    chk_ev("long_rep3", 4, 0, 3);
    if (lg.size() > 2) chk("rep_gap", lg[2].c - lg[1].c, 12);

    // all buttons at once from rr_ptr = 0
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    step(2);
    lg.delete();
    btn_in = 4'b0000;
    step(10);
    chk("rr_count", lg.size(), 4);
    for (int i = 0; i < 4; i++) chk_ev("rr", i, i, 0);
    if (lg.size() > 3) chk("rr_b2b", lg[3].c - lg[0].c, 3);
    btn_in = 4'hF;
    step(10);

    // stalled consumer, overflow and clear
    lg.delete();
    ev_ready = 1'b0;
    btn_in = 4'b1101; step(4);
    btn_in = 4'hF;    step(4);
    btn_in = 4'b1101; step(4);
    btn_in = 4'hF;    step(4);
    chk("stall_valid", ev_valid, 1);
    chk("stall_btn", ev_btn, 1);
    chk("stall_type", ev_type, 0);
    chk("stall_ovf", ovf, 1);
    ovf_clr = 1'b1; step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    step(1);
    ev_ready = 1'b1;
    step(5);
    chk("drain_count", lg.size(), 2);
    chk_ev("drain_press", 0, 1, 0);
    chk_ev("drain_rel", 1, 1, 1);

    // reset while held with an event stuck at the output
    ev_ready = 1'b0;
    btn_in = 4'b0111;
    step(50);
    chk("held_valid", ev_valid, 1);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    chk("rst_mid_valid", ev_valid, 0);
    chk("rst_mid_ovf", ovf, 0);
    lg.delete();
    ev_ready = 1'b1;
    step(10);
    chk("fresh_count", lg.size(), 1);
    chk_ev("fresh_press", 0, 3, 0);
    btn_in = 4'hF;
    step(6);
    chk("fresh_total", lg.size(), 2);
    chk_ev("fresh_rel", 1, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button channels (1..8).
REQ-002 SHALL have parameter CLK_HZ, default 27000000, clk frequency in Hz.
REQ-003 SHALL have parameter LONG_MS, default 1000, hold time in ms before a long-press event (1..65535).
REQ-004 SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms after a long press (1..65535).
REQ-005 SHALL have parameter IDLE_STATE, default 1'b1, btn_in level meaning "released".
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have port btn_in, input, N_BTN, debounced button levels, already synchronous to clk.
REQ-009 SHALL have port ev_valid, output, 1, event available.
REQ-010 SHALL have port ev_ready, input, 1, consumer accepts the event.
REQ-011 SHALL have port ev_btn, output, 3, index of the button that raised the event.
REQ-012 SHALL have port ev_type, output, 2, event code: 00 PRESS, 01 SHORT_RELEASE, 10 LONG, 11 REPEAT.
REQ-013 SHALL have port ovf, output, 1, sticky flag: an event was lost.
REQ-014 SHALL have port ovf_clr, input, 1, single-cycle clear of ovf.

Function
REQ-015 SHALL generate a 1 ms tick: a prescaler counts 0..CLK_HZ/1000-1 and pulses tick for one clk when it wraps.
REQ-016 SHALL treat button i as active when btn_in[i] != IDLE_STATE.
REQ-017 SHALL run one FSM per button with states IDLE, PRESSED, HELD, plus a 16-bit ms counter per button.
REQ-018 IDLE: on active -> PRESSED; raise PRESS; clear ms counter.
REQ-019 PRESSED: on tick, increment ms counter; on release -> IDLE and raise SHORT_RELEASE; when the counter reaches LONG_MS -> HELD, raise LONG, clear counter.
REQ-020 HELD: on tick, increment counter; when it reaches REPEAT_MS raise REPEAT and clear counter; on release -> IDLE with no event.
REQ-021 Release and threshold in the same cycle: release SHALL win (PRESSED -> SHORT_RELEASE only; HELD -> IDLE, no REPEAT).
REQ-022 Each button SHALL hold one pending event slot (pending bit + 2-bit type).
REQ-023 New event while the slot is pending and not being granted this cycle: the new event SHALL be dropped and ovf set.
REQ-024 New event in the same cycle its pending slot is granted: the new event SHALL be stored, with no overflow.
REQ-025 Output register SHALL be loadable when ev_valid=0 or (ev_valid & ev_ready); back-to-back events SHALL then issue at 1 per clk.
REQ-026 Arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to i, rr_ptr = (i+1) mod N_BTN; a grant clears that pending bit.
REQ-027 While ev_valid=1 and ev_ready=0, ev_btn and ev_type SHALL stay stable.
REQ-028 ovf_clr SHALL clear ovf; an overflow in the same cycle SHALL win (ovf stays 1).
REQ-029 Latency SHALL be 2 clk from a btn_in edge to ev_valid when the output is idle and no other button is pending.

Reset
REQ-030 With rstn=0 at a clk edge, the block SHALL set all FSMs to IDLE, clear ms counters, prescaler, pending bits and rr_ptr, and drive ev_valid=0, ev_btn=0, ev_type=0, ovf=0.
REQ-031 Reset mid-press SHALL discard in-flight events; a button still active after reset SHALL raise PRESS once.

Verification (CLK_HZ=4000 so tick = every 4 clk, LONG_MS=10, REPEAT_MS=3, N_BTN=4, ev_ready=1 unless stated)
REQ-032 Button 2 active for 5 ms, then released -> PRESS(2), then SHORT_RELEASE(2); no LONG.
REQ-033 Button 0 held for 20 ms -> PRESS, LONG at about 10 ms, REPEAT at 13, 16 and 19 ms; release -> no further event.
REQ-034 Buttons 0..3 pressed in the same cycle, rr_ptr=0 -> PRESS events issued in order 0,1,2,3 on consecutive clks.
REQ-035 ev_ready=0 while button 1 is pressed and released twice -> first PRESS held stable, later events dropped, ovf=1; ovf_clr pulse -> ovf=0.
REQ-036 rstn=0 for 1 clk during HELD with ev_valid=1 -> ev_valid=0 next clk; button still active -> one fresh PRESS.
